// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the instruction-download path:
// loader states, frame marker and ICache geometry.
package cpu_pkg;

  localparam int         LOADER_INDEX_W   = 8;
  localparam int         ICACHE_DEPTH     = 2 ** LOADER_INDEX_W;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and ICache write-port bundle of the program loader.
// Handshake: a byte transfers on a rising clk edge where byte_valid && byte_ready;
// byte_data must be stable while byte_valid is high, and byte_ready never depends on byte_valid.
interface program_loader_if
  import cpu_pkg::*;
#(
  parameter int INDEX_W = LOADER_INDEX_W
);
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               write;
  logic [INDEX_W-1:0] write_instruction_index;
  logic [15:0]        write_instruction;
  logic               load_done;
  logic [INDEX_W:0]   words_loaded;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, write, write_instruction_index, write_instruction,
           load_done, words_loaded
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, write, write_instruction_index, write_instruction,
           load_done, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Frames a byte stream (sync, word count, halfwords) into ICache writes.
// write doubles as the CPU stall, so it is held high across the whole load.
module program_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE,
  parameter int         INDEX_W   = LOADER_INDEX_W
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.master bus,
  output loader_state_e    dbg_state_o
);

  localparam int                CNT_W      = INDEX_W + 1;
  localparam logic [CNT_W-1:0]  FULL_FRAME = CNT_W'(2 ** INDEX_W);

  loader_state_e      state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   wl_q, wl_d;
  logic [15:0]        wi_q, wi_d;
  logic [INDEX_W-1:0] widx_q, widx_d;
  logic               write_q, write_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               accept;
  logic [CNT_W-1:0]   wl_inc;

  assign accept = bus.byte_valid & ready_q;
  assign wl_inc = wl_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SYNC;
      hi_q    <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      wl_q    <= '0;
      wi_q    <= '0;
      widx_q  <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      wi_q    <= wi_d;
      widx_q  <= widx_d;
      write_q <= write_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    n_d     = n_q;
    wl_d    = wl_q;
    wi_d    = wi_q;
    widx_d  = widx_q;
    write_d = write_q;
    case (state_q)
      ST_SYNC: begin
        if (accept && bus.byte_data == SYNC_BYTE) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (accept) begin
          // A zero count byte stands for a full ICache image.
          n_d     = (bus.byte_data == 8'd0) ? FULL_FRAME : CNT_W'(bus.byte_data);
          wl_d    = '0;
          idx_d   = '0;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_d    = bus.byte_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          wi_d    = {hi_q, bus.byte_data};
          widx_d  = idx_q;
          write_d = 1'b1;
          idx_d   = idx_q + INDEX_W'(1);
          wl_d    = wl_inc;
          state_d = (wl_inc == n_q) ? ST_FLUSH : ST_HI;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_SYNC;
      default:  state_d = ST_SYNC;
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    if (state_d == ST_DONE) write_d = 1'b0;
    ready_d = !(state_d == ST_FLUSH || state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  assign bus.byte_ready              = ready_q;
  assign bus.write                   = write_q;
  assign bus.write_instruction_index = widx_q;
  assign bus.write_instruction       = wi_q;
  assign bus.load_done               = done_q;
  assign bus.words_loaded            = wl_q;
  assign dbg_state_o                 = state_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU instruction-download interface (write, write_instruction_index, write_instruction).
- Receives a byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Frames the stream as: sync byte, word count, then instruction halfwords.
- Drives the ICache write port. The write line also stalls the CPU through its clock gating.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker; any other byte received in SYNC is discarded.
- INDEX_W, 8, width of the instruction index; the maximum frame is 2**INDEX_W words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  incoming stream byte
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready
- write  output  1  ICache write enable and CPU stall
- write_instruction_index  output  INDEX_W  ICache word address
- write_instruction  output  16  halfword to store, in memory byte order
- load_done  output  1  one-cycle pulse when a frame has been fully written
- words_loaded  output  INDEX_W+1  number of words written in the current or last frame

Behaviour:
- Reset values: all outputs 0, except byte_ready=1; state=SYNC.
- All outputs are registered. Reset can assert at any point, including mid-frame:
  - write drops immediately (asynchronously).
  - State returns to SYNC.
  - Partially loaded memory is left as is.
- States: SYNC, COUNT, HI, LO, FLUSH, DONE. Each accepted byte advances the state by at most one step.
- SYNC:
  - Accepted byte == SYNC_BYTE -> COUNT.
  - Any other byte is dropped and the state stays SYNC.
- COUNT:
  - Accepted byte c sets the total word count N = (c==0) ? 256 : c.
  - Clears words_loaded and the word index.
  - Next state -> HI.
- HI:
  - Accepted byte is latched as the upper byte. The first stream byte becomes write_instruction[15:8]; the CPU's inverter performs the endian swap.
  - Next state -> LO.
- LO, on the edge that accepts the byte:
  - write_instruction <= {hi, byte}
  - write_instruction_index <= idx
  - write <= 1
  - idx <= idx+1
  - words_loaded <= words_loaded+1
  - If this was word N -> FLUSH; otherwise -> HI.
- Write window:
  - write rises on the first completed word and stays high continuously until FLUSH ends, so the CPU stays stalled for the whole load.
  - Between words, the ICache rewrites the last word at the same index. This is idempotent and required behaviour.
  - Latency: a word is committed at the clock edge after its LO byte is accepted.
- FLUSH (1 cycle):
  - byte_ready=0 and write=1, so the last word is committed at the end of this cycle.
  - Next state -> DONE.
- DONE (1 cycle):
  - write=0, load_done=1, byte_ready=0.
  - Next state -> SYNC.
  - words_loaded holds N until the next COUNT byte.
- byte_ready:
  - 1 in SYNC, COUNT, HI and LO.
  - 0 in FLUSH and DONE; bytes offered then are not consumed.
- Index wrap: N=256 covers idx 0..255. idx never exceeds N-1, so there is no wrap within a frame.
- A SYNC_BYTE value arriving in HI or LO is treated as data. There is no resync inside a frame; only reset aborts a frame.
- byte_valid low for any number of cycles simply holds the state. During a gap inside a frame, write stays high.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the loader state enum
  - the SYNC_BYTE constant
  - the ICache depth constant, tied to INDEX_W
- A single flat module. No sub-module; the byte handshake is too small to split out.

Test Plan:
- Reset, then bytes A5,02,12,34,56,78 sent back-to-back.
  - Writes seen: index0=16'h1234, then index1=16'h5678.
  - write stays high from the first commit through FLUSH.
  - load_done pulses once; words_loaded=2.
- Garbage 00,FF,5A before A5,01,AB,CD.
  - The garbage bytes are consumed with no write.
  - Then index0=16'hABCD and load_done fires.
- Count byte 00 followed by 512 data bytes.
  - 256 words are written at indices 0..255; words_loaded=256.
  - Word 255 is committed on the FLUSH edge.
- byte_valid toggled at random during a 3-word frame.
  - Identical ICache contents result.
  - write never drops mid-frame once risen.
  - byte_ready=0 exactly in FLUSH and DONE.
- Reset asserted after the HI byte of word 1 of a 4-word frame.
  - write=0 immediately; state returns to SYNC.
  - A following full frame loads correctly from index 0.
- A5 sent as a data byte inside a frame (A5,01,A5,A5).
  - index0=16'hA5A5; no resync occurs.
